// File: rtl/proc_pkg.sv
// Shared constants for the bus-processor control sequencer: field widths,
// opcode values and timestep encodings.
package proc_pkg;

  localparam int NREG = 8;
  localparam int RW   = 3;
  localparam int OPW  = 3;
  localparam int IRW  = OPW + 2 * RW;

  localparam logic [OPW-1:0] OP_MV  = 3'b000;
  localparam logic [OPW-1:0] OP_MVI = 3'b001;
  localparam logic [OPW-1:0] OP_ADD = 3'b010;
  localparam logic [OPW-1:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

endpackage

// File: rtl/proc_control_dec_onehot.sv
// Register-index to one-hot line decoder; all lines low when disabled.
module dec_onehot
  import proc_pkg::*;
(
  input  logic            en,
  input  logic [RW-1:0]   idx,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/proc_control.sv
// Multi-cycle control sequencer: steps each instruction through T0..T3 and
// decodes the instruction register into one-hot register and bus enables.
module proc_control
  import proc_pkg::*;
(
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Run,
  input  logic [IRW-1:0]  IR,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            DINout,
  output logic            Gout,
  output logic            Ain,
  output logic            Gin,
  output logic            AddSub,
  output logic            Done,
  output logic            Illegal,
  output logic            Busy,
  output logic [1:0]      state_dbg
);

  state_e state_q, state_d;

  logic [OPW-1:0]  op;
  logic [RW-1:0]   x_idx, y_idx;
  logic            is_alu;
  logic            rin_en, rout_x_en, rout_y_en;
  logic [NREG-1:0] x_oh, y_oh;

  assign op     = IR[IRW-1 -: OPW];
  assign x_idx  = IR[2*RW-1 -: RW];
  assign y_idx  = IR[RW-1:0];
  assign is_alu = (op == OP_ADD) || (op == OP_SUB);

  always_comb begin
    state_d = T0;
    case (state_q)
      T0:      state_d = Run ? T1 : T0;
      T1:      state_d = is_alu ? T2 : T0;
      T2:      state_d = T3;
      T3:      state_d = T0;
      default: state_d = T0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= T0;
    else         state_q <= state_d;
  end

  // Every output is qualified by Resetn so reset silences the bus at once,
  // including IRin, which otherwise follows Run in T0.
  always_comb begin
    IRin      = 1'b0;
    DINout    = 1'b0;
    Gout      = 1'b0;
    Ain       = 1'b0;
    Gin       = 1'b0;
    AddSub    = 1'b0;
    Done      = 1'b0;
    Illegal   = 1'b0;
    rin_en    = 1'b0;
    rout_x_en = 1'b0;
    rout_y_en = 1'b0;
    if (Resetn) begin
      case (state_q)
        T0: IRin = Run;
        T1: begin
          case (op)
            OP_MV: begin
              rout_y_en = 1'b1;
              rin_en    = 1'b1;
              Done      = 1'b1;
            end
            OP_MVI: begin
              DINout = 1'b1;
              rin_en = 1'b1;
              Done   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              rout_x_en = 1'b1;
              Ain       = 1'b1;
            end
            default: begin
              Done    = 1'b1;
              Illegal = 1'b1;
            end
          endcase
        end
        T2: begin
          rout_y_en = 1'b1;
          Gin       = 1'b1;
          AddSub    = (op == OP_SUB);
        end
        T3: begin
          Gout   = 1'b1;
          rin_en = 1'b1;
          Done   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  dec_onehot u_dec_x (
    .en     (rin_en | rout_x_en),
    .idx    (x_idx),
    .onehot (x_oh)
  );

  dec_onehot u_dec_y (
    .en     (rout_y_en),
    .idx    (y_idx),
    .onehot (y_oh)
  );

  // X drives the bus only in add/sub T1; Y only in mv T1 and T2, never together.
  assign Rin       = rin_en ? x_oh : '0;
  assign Rout      = (rout_x_en ? x_oh : '0) | y_oh;
  assign Busy      = Resetn && (state_q != T0);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_proc_control.sv
// Directed and randomised checks of the proc_control sequencer outputs.
module tb_proc_control;

  logic       Clock;
  logic       Resetn;
  logic       Run;
  logic [8:0] IR;
  logic       IRin, DINout, Gout, Ain, Gin, AddSub, Done, Illegal, Busy;
  logic [7:0] Rin, Rout;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  proc_control dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Run       (Run),
    .IR        (IR),
    .IRin      (IRin),
    .Rin       (Rin),
    .Rout      (Rout),
    .DINout    (DINout),
    .Gout      (Gout),
    .Ain       (Ain),
    .Gin       (Gin),
    .AddSub    (AddSub),
    .Done      (Done),
    .Illegal   (Illegal),
    .Busy      (Busy),
    .state_dbg (state_dbg)
  );

  // clock/reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Illegal, Busy}
  logic [24:0] out_vec;
  assign out_vec = {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Illegal, Busy};

  function automatic logic [24:0] ev(input logic irin, input logic [7:0] rin,
                                     input logic [7:0] rout, input logic din,
                                     input logic gout, input logic ain, input logic gin,
                                     input logic addsub, input logic done,
                                     input logic ill, input logic busy);
    return {irin, rin, rout, din, gout, ain, gin, addsub, done, ill, busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: inputs change on the falling edge, outputs are sampled 1ns later
  task automatic step(input logic run, input logic [8:0] ir);
    @(negedge Clock);
    Run = run;
    IR  = ir;
    #1;
  endtask

  logic [24:0] idle;
  int          m_state;
  logic [8:0]  r_ir;
  logic        r_run;
  logic        m_alu;
  logic        bus_ok, m_done;
  logic [9:0]  bus_lines;

  initial begin
    idle   = '0;
    Resetn = 1'b0;
    Run    = 1'b1;
    IR     = 9'b011_001_011;
    #12;
    check("reset_all_zero", 32'(out_vec), 32'(idle));

    // release reset, no Run: stays idle
    @(negedge Clock);
    Resetn = 1'b1;
    Run    = 1'b0;
    #1;
    check("idle_t0_a", 32'(out_vec), 32'(idle));
    step(1'b0, 9'b000_010_101);
    check("idle_t0_b", 32'(out_vec), 32'(idle));

    // mv R2,R5
    step(1'b1, 9'b000_010_101);
    check("mv_t0", 32'(out_vec), 32'(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0)));
    step(1'b0, 9'b000_010_101);
    check("mv_t1", 32'(out_vec), 32'(ev(0, 8'h04, 8'h20, 0, 0, 0, 0, 0, 1, 0, 1)));
    step(1'b0, 9'b000_010_101);
    check("mv_after", 32'(out_vec), 32'(idle));

    // mvi R7
    step(1'b1, 9'b001_111_000);
    check("mvi_t0", 32'(out_vec), 32'(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0)));
    step(1'b0, 9'b001_111_000);
    check("mvi_t1", 32'(out_vec), 32'(ev(0, 8'h80, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1)));
    step(1'b0, 9'b001_111_000);
    check("mvi_after", 32'(out_vec), 32'(idle));

    // sub R1,R3
    step(1'b1, 9'b011_001_011);
    check("sub_t0", 32'(out_vec), 32'(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0)));
    step(1'b0, 9'b011_001_011);
    check("sub_t1", 32'(out_vec), 32'(ev(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 0, 1)));
    step(1'b0, 9'b011_001_011);
    check("sub_t2", 32'(out_vec), 32'(ev(0, 8'h00, 8'h08, 0, 0, 0, 1, 1, 0, 0, 1)));
    step(1'b0, 9'b011_001_011);
    check("sub_t3", 32'(out_vec), 32'(ev(0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1, 0, 1)));
    step(1'b0, 9'b011_001_011);
    check("sub_after", 32'(out_vec), 32'(idle));

    // add R1,R3
    step(1'b1, 9'b010_001_011);
    check("add_t0", 32'(out_vec), 32'(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0)));
    step(1'b0, 9'b010_001_011);
    check("add_t1", 32'(out_vec), 32'(ev(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 0, 1)));
    step(1'b0, 9'b010_001_011);
    check("add_t2", 32'(out_vec), 32'(ev(0, 8'h00, 8'h08, 0, 0, 0, 1, 0, 0, 0, 1)));
    step(1'b0, 9'b010_001_011);
    check("add_t3", 32'(out_vec), 32'(ev(0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1, 0, 1)));
    step(1'b0, 9'b010_001_011);
    check("add_after", 32'(out_vec), 32'(idle));

    // illegal opcode
    step(1'b1, 9'b111_000_000);
    check("ill_t0", 32'(out_vec), 32'(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0)));
    step(1'b0, 9'b111_000_000);
    check("ill_t1", 32'(out_vec), 32'(ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1)));
    step(1'b0, 9'b111_000_000);
    check("ill_after", 32'(out_vec), 32'(idle));

    // Run held high: add R4,R6 then mv R3,R3 back-to-back
    step(1'b1, 9'b010_100_110);
    check("hold_add_t0", 32'(out_vec), 32'(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0)));
    step(1'b1, 9'b010_100_110);
    check("hold_add_t1", 32'(out_vec), 32'(ev(0, 8'h00, 8'h10, 0, 0, 1, 0, 0, 0, 0, 1)));
    step(1'b1, 9'b010_100_110);
    check("hold_add_t2", 32'(out_vec), 32'(ev(0, 8'h00, 8'h40, 0, 0, 0, 1, 0, 0, 0, 1)));
    step(1'b1, 9'b010_100_110);
    check("hold_add_t3", 32'(out_vec), 32'(ev(0, 8'h10, 8'h00, 0, 1, 0, 0, 0, 1, 0, 1)));
    step(1'b1, 9'b000_011_011);
    check("hold_mv_t0", 32'(out_vec), 32'(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0)));
    step(1'b1, 9'b000_011_011);
    check("hold_mv_t1", 32'(out_vec), 32'(ev(0, 8'h08, 8'h08, 0, 0, 0, 0, 0, 1, 0, 1)));
    step(1'b0, 9'b000_011_011);
    check("hold_after", 32'(out_vec), 32'(idle));

    // reset asserted in the middle of a sub, away from any clock edge
    step(1'b1, 9'b011_010_100);
    step(1'b0, 9'b011_010_100);
    step(1'b1, 9'b011_010_100);
    check("rst_mid_t2", 32'(out_vec), 32'(ev(0, 8'h00, 8'h10, 0, 0, 0, 1, 1, 0, 0, 1)));
    #2;
    Resetn = 1'b0;
    #1;
    check("rst_mid_zero", 32'(out_vec), 32'(idle));
    check("rst_mid_state", 32'(state_dbg), 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    Run    = 1'b0;
    #1;
    check("rst_release_t0", 32'(out_vec), 32'(idle));
    step(1'b0, 9'b011_010_100);
    check("rst_release_stay", 32'(out_vec), 32'(idle));

    // random IR/Run with a timestep model; IR only changes while idle
    m_state = 0;
    r_ir    = '0;
    for (int i = 0; i < 1000; i++) begin
      r_run = 1'($urandom_range(0, 1));
      if (m_state == 0) r_ir = 9'($urandom_range(0, 511));
      step(r_run, r_ir);
      m_alu     = (r_ir[8:6] == 3'b010) || (r_ir[8:6] == 3'b011);
      m_done    = (m_state == 1 && !m_alu) || (m_state == 3);
      bus_lines = {Rout, DINout, Gout};
      bus_ok    = ($countones(bus_lines) <= 1) && ($countones(Rin) <= 1);
      check("rnd_busy", 32'(Busy), 32'(m_state != 0));
      check("rnd_done", 32'(Done), 32'(m_done));
      check("rnd_irin", 32'(IRin), 32'(m_state == 0 && r_run));
      check("rnd_illegal", 32'(Illegal), 32'(m_state == 1 && r_ir[8]));
      check("rnd_bus_invariant", 32'(bus_ok), 32'd1);
      case (m_state)
        0:       m_state = r_run ? 1 : 0;
        1:       m_state = m_alu ? 2 : 0;
        2:       m_state = 3;
        default: m_state = 0;
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
